mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side stage downstream of the multi-cycle controller. Captures the controller's
//  one-cycle mem_read/mem_write strobes with address and write data, then runs a
//  req/ack transaction to a variable-latency external memory. Returns read data
//  registered, with a done pulse, a busy flag and error/timeout reporting.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  15  max cycles in ISSUE waiting for ext_ack (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       asynchronous, active-low reset
//  mem_read   in   1       read strobe from controller
//  mem_write  in   1       write strobe from controller
//  addr       in   ADDR_W  byte address, sampled on accept
//  wdata      in   DATA_W  write data, sampled on accept
//  rdata      out  DATA_W  registered read data, held until next read completes
//  done       out  1       1-cycle pulse: transaction finished (read or write)
//  busy       out  1       1 while a transaction is pending (ISSUE or DONE state)
//  err        out  1       1-cycle pulse with done when transaction timed out
//  overrun    out  1       sticky: request arrived while busy, or read+write together
//  ext_req    out  1       request to external memory, held until ext_ack
//  ext_we     out  1       1=write, 0=read; stable while ext_req=1
//  ext_addr   out  ADDR_W  latched address; stable while ext_req=1
//  ext_wdata  out  DATA_W  latched write data; stable while ext_req=1
//  ext_rdata  in   DATA_W  external read data, valid in the cycle ext_ack=1
//  ext_ack    in   1       external completion, single cycle
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; rdata=0, done=0, busy=0, err=0, overrun=0,
//   ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, timeout count=0. Reset mid-
//   transaction aborts it immediately; no done/err is produced for it.
//  FSM states: IDLE, ISSUE, DONE.
//  IDLE: accept iff exactly one of mem_read/mem_write=1. On accept edge: latch
//   addr/wdata into ext_addr/ext_wdata, ext_we=mem_write, ext_req=1, count=0 -> ISSUE.
//   Both strobes=1: no accept, overrun<=1, stay IDLE.
//  ISSUE: busy=1, ext_req=1. Edge with ext_ack=1: ext_req<=0; if read, rdata<=ext_rdata;
//   -> DONE. Else count+1; edge where count reaches TIMEOUT with no ack: ext_req<=0,
//   err<=1, rdata unchanged (read) -> DONE. Ack and timeout same edge: ack wins, err=0.
//  DONE: done=1 for exactly one cycle (err=1 that cycle on timeout), busy=1 -> IDLE.
//   A new request is not accepted in DONE; earliest accept is the cycle after done.
//  Any mem_read/mem_write=1 seen in ISSUE or DONE: ignored, overrun<=1 (sticky
//   until reset).
//  ext_ack while not in ISSUE: ignored, no state change.
//  Latency: strobe at edge 0 -> ext_req high after edge 0; ack sampled at edge k ->
//   done high between edges k and k+1; minimum strobe-to-done = 2 cycles.
//  Outputs done, err, busy, ext_* are all registered (no comb path from inputs).
//  rdata updates only on a successful read ack; writes never change rdata.
// TESTING
//  1 Reset: rst=0 mid-ISSUE -> ext_req, busy, done drop to 0 without clk edge.
//  2 Read, ack after 3 cycles, ext_rdata=32'hDEADBEEF, addr=32'h40 -> ext_addr=32'h40,
//    ext_we=0, done pulse 1 cycle, rdata=32'hDEADBEEF, err=0.
//  3 Write addr=32'h80 wdata=32'h1234, ack next cycle -> ext_we=1, ext_wdata=32'h1234,
//    done after 2 cycles, rdata unchanged.
//  4 Read, no ack, TIMEOUT=15 -> ext_req drops after 15 ISSUE cycles, done=err=1 once;
//    late ext_ack afterwards ignored.
//  5 mem_read during ISSUE, then mem_read=mem_write=1 in IDLE -> both ignored,
//    overrun=1 sticky, no extra ext_req.
//  6 Back-to-back: second read strobe in cycle after done -> accepted, ext_req re-asserted.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-side access stage: captures one-cycle read/write strobes and runs a
// req/ack transaction to a variable-latency external memory with timeout.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              overrun,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_any;
  logic             req_one;

  always_comb begin
    req_any = mem_read | mem_write;
    req_one = mem_read ^ mem_write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_one) begin
            ext_addr  <= addr;
            ext_wdata <= wdata;
            ext_we    <= mem_write;
            ext_req   <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= S_ISSUE;
          end else if (req_any) begin
            overrun <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (req_any) overrun <= 1'b1;
          // Ack takes priority over a timeout expiring on the same edge.
          if (ext_ack) begin
            ext_req <= 1'b0;
            done    <= 1'b1;
            if (!ext_we) rdata <= ext_rdata;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              ext_req <= 1'b0;
              done    <= 1'b1;
              err     <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (req_any) overrun <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-edge vector table plus hand-written
// sequences for timeout, late ack and asynchronous reset mid-transaction.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic        overrun;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .err(err), .overrun(overrun), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .ext_ack(ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] xrd;
    logic        ack;
    logic [31:0] e_rdata;
    logic        e_done;
    logic        e_busy;
    logic        e_err;
    logic        e_ovr;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  localparam int NV = 22;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_rdata, input logic e_done,
                         input logic e_busy, input logic e_err, input logic e_ovr,
                         input logic e_req, input logic e_we, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata);
    chk({tag, ".rdata"},     rdata,     e_rdata);
    chk({tag, ".done"},      32'(done),    32'(e_done));
    chk({tag, ".busy"},      32'(busy),    32'(e_busy));
    chk({tag, ".err"},       32'(err),     32'(e_err));
    chk({tag, ".overrun"},   32'(overrun), 32'(e_ovr));
    chk({tag, ".ext_req"},   32'(ext_req), 32'(e_req));
    chk({tag, ".ext_we"},    32'(ext_we),  32'(e_we));
    chk({tag, ".ext_addr"},  ext_addr,  e_addr);
    chk({tag, ".ext_wdata"}, ext_wdata, e_wdata);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] xrd, input logic ack);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    ext_rdata = xrd;
    ext_ack   = ack;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] xrd, input logic ack,
                      input logic [31:0] e_rdata, input logic e_done, input logic e_busy,
                      input logic e_err, input logic e_ovr, input logic e_req,
                      input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata);
    vt[i] = '{rd, wr, a, wd, xrd, ack, e_rdata, e_done, e_busy, e_err, e_ovr,
              e_req, e_we, e_addr, e_wdata};
  endtask

  initial begin
    //        rd wr addr          wdata         ext_rdata     ack  rdata         dn bz er ov rq we ext_addr      ext_wdata
    setv( 0, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
    setv( 1, 1, 0, 32'h40,       32'h0,        32'h0,        0,   32'h0,        0, 1, 0, 0, 1, 0, 32'h40,       32'h0);
    setv( 2, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h0,        0, 1, 0, 0, 1, 0, 32'h40,       32'h0);
    setv( 3, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h0,        0, 1, 0, 0, 1, 0, 32'h40,       32'h0);
    setv( 4, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 1,   32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 32'h40,       32'h0);
    setv( 5, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h40,       32'h0);
    setv( 6, 0, 1, 32'h80,       32'h1234,     32'h0,        0,   32'hDEADBEEF, 0, 1, 0, 0, 1, 1, 32'h80,       32'h1234);
    setv( 7, 0, 0, 32'h0,        32'h0,        32'hCAFEF00D, 1,   32'hDEADBEEF, 1, 1, 0, 0, 0, 1, 32'h80,       32'h1234);
    setv( 8, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 32'h80,       32'h1234);
    setv( 9, 0, 0, 32'h0,        32'h0,        32'h11111111, 1,   32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 32'h80,       32'h1234);
    setv(10, 1, 0, 32'h44,       32'h0,        32'h0,        0,   32'hDEADBEEF, 0, 1, 0, 0, 1, 0, 32'h44,       32'h0);
    setv(11, 0, 0, 32'h0,        32'h0,        32'h12345678, 1,   32'h12345678, 1, 1, 0, 0, 0, 0, 32'h44,       32'h0);
    setv(12, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h12345678, 0, 0, 0, 0, 0, 0, 32'h44,       32'h0);
    setv(13, 1, 0, 32'h48,       32'h0,        32'h0,        0,   32'h12345678, 0, 1, 0, 0, 1, 0, 32'h48,       32'h0);
    setv(14, 0, 0, 32'h0,        32'h0,        32'h0BADF00D, 1,   32'h0BADF00D, 1, 1, 0, 0, 0, 0, 32'h48,       32'h0);
    setv(15, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'h0BADF00D, 0, 0, 0, 0, 0, 0, 32'h48,       32'h0);
    setv(16, 1, 0, 32'hC0,       32'h0,        32'h0,        0,   32'h0BADF00D, 0, 1, 0, 0, 1, 0, 32'hC0,       32'h0);
    setv(17, 1, 0, 32'h100,      32'h77,       32'h0,        0,   32'h0BADF00D, 0, 1, 0, 1, 1, 0, 32'hC0,       32'h0);
    setv(18, 0, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 1,   32'hA5A5A5A5, 1, 1, 0, 1, 0, 0, 32'hC0,       32'h0);
    setv(19, 0, 1, 32'h104,      32'h99,       32'h0,        0,   32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 32'hC0,       32'h0);
    setv(20, 1, 1, 32'h108,      32'h55,       32'h0,        0,   32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 32'hC0,       32'h0);
    setv(21, 0, 0, 32'h0,        32'h0,        32'h0,        0,   32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 32'hC0,       32'h0);

    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
    #1 rst = 1'b0;
    #2;
    chk_all("reset", 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #9 rst = 1'b1;
    edge_step();

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, vt[i].xrd, vt[i].ack);
      edge_step();
      chk_all($sformatf("v%0d", i), vt[i].e_rdata, vt[i].e_done, vt[i].e_busy, vt[i].e_err,
              vt[i].e_ovr, vt[i].e_req, vt[i].e_we, vt[i].e_addr, vt[i].e_wdata);
    end

    // Timeout: no ack for 15 ISSUE cycles, then late acks ignored
    drive(1, 0, 32'h200, 32'h0, 32'h0, 0);
    edge_step();
    chk_all("to_accept", 32'hA5A5A5A5, 0, 1, 0, 1, 1, 0, 32'h200, 32'h0);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
    for (int i = 1; i < 15; i++) begin
      edge_step();
      chk($sformatf("to_wait%0d.ext_req", i), 32'(ext_req), 32'd1);
      chk($sformatf("to_wait%0d.done", i), 32'(done), 32'd0);
    end
    edge_step();
    chk_all("to_expire", 32'hA5A5A5A5, 1, 1, 1, 1, 0, 0, 32'h200, 32'h0);
    drive(0, 0, 32'h0, 32'h0, 32'hFFFF0000, 1);
    edge_step();
    chk_all("to_late_ack", 32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 32'h200, 32'h0);
    edge_step();
    chk_all("to_late_ack2", 32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 32'h200, 32'h0);

    // Asynchronous reset in the middle of ISSUE
    drive(0, 1, 32'h300, 32'hBEEF, 32'h0, 0);
    edge_step();
    chk_all("rst_pre", 32'hA5A5A5A5, 0, 1, 0, 1, 1, 1, 32'h300, 32'hBEEF);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
    #2 rst = 1'b0;
    #1;
    chk_all("rst_mid", 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    edge_step();
    chk_all("rst_hold", 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #3 rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 32'h13579BDF, 1);
    edge_step();
    chk_all("rst_after", 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
